// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: ROM geometry, reset PC, bubble encoding and
// the ROM-port arbiter state encoding.
package cpu_pkg;

  localparam int ADDR_W = 6;
  localparam int INST_W = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam addr_t RESET_PC = 6'h01;
  localparam inst_t NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_STEAL = 2'd2
  } arb_state_e;

  // PC advance; the address width makes 6'h3F roll over to 6'h00.
  function automatic addr_t pc_inc(addr_t pc);
    return pc + addr_t'(1);
  endfunction

endpackage

// File: rtl/ifetch_seq_arb_if.sv
// Fetch/ROM/debug bundle between the fetch sequencer (slave) and the rest of
// the core, the ROM and the debug loader (master).
interface ifetch_seq_arb_if;
  import cpu_pkg::*;

  addr_t rom_a;
  inst_t rom_inst;
  logic  stall;
  logic  br_taken;
  addr_t br_target;
  logic  jmp;
  addr_t jmp_target;
  inst_t if_inst;
  addr_t if_pc;
  logic  if_valid;
  logic  dbg_req;
  addr_t dbg_addr;
  logic  dbg_gnt;
  inst_t dbg_data;
  logic  dbg_valid;

  modport slave (
    input  rom_inst, stall, br_taken, br_target, jmp, jmp_target, dbg_req, dbg_addr,
    output rom_a, if_inst, if_pc, if_valid, dbg_gnt, dbg_data, dbg_valid
  );

  modport master (
    output rom_inst, stall, br_taken, br_target, jmp, jmp_target, dbg_req, dbg_addr,
    input  rom_a, if_inst, if_pc, if_valid, dbg_gnt, dbg_data, dbg_valid
  );

endinterface

// File: rtl/rom_port_arb.sv
// ROM address-port arbiter: debug reads ride on stall cycles for free, and a
// fetch cycle is stolen once a request has waited STARVE_MAX+1 cycles.
module rom_port_arb
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req_i,
  input  logic stall_i,
  input  logic redirect_i,
  output logic dbg_gnt_o,
  output logic steal_o
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] wait_cnt_q;

  assign steal_o   = (state_q == ARB_STEAL);
  // A redirect needs the fetch slot, so it blocks the free ride on a stall.
  assign dbg_gnt_o = dbg_req_i & ~rst & (steal_o | (stall_i & ~redirect_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (dbg_req_i && !dbg_gnt_o) begin
            state_q    <= ARB_WAIT;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        ARB_WAIT: begin
          if (dbg_gnt_o || !dbg_req_i) begin
            state_q    <= ARB_IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == CNT_W'(STARVE_MAX)) begin
            state_q    <= ARB_STEAL;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        ARB_STEAL: begin
          state_q    <= ARB_IDLE;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= ARB_IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ifetch_seq_arb.sv
// Instruction-fetch sequencer: owns the PC and the IF/ID register, applies
// redirects with a one-slot bubble, and shares the ROM port with debug reads.
module ifetch_seq_arb
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  ifetch_seq_arb_if.slave  bus
);

  addr_t pc_q;
  inst_t if_inst_q;
  addr_t if_pc_q;
  logic  if_valid_q;
  inst_t dbg_data_q;
  logic  dbg_valid_q;

  logic  redirect;
  addr_t target;
  logic  dbg_gnt;
  logic  steal;

  assign redirect = bus.br_taken | bus.jmp;
  assign target   = bus.br_taken ? bus.br_target : bus.jmp_target;

  rom_port_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .dbg_req_i  (bus.dbg_req),
    .stall_i    (bus.stall),
    .redirect_i (redirect),
    .dbg_gnt_o  (dbg_gnt),
    .steal_o    (steal)
  );

  assign bus.rom_a     = dbg_gnt ? bus.dbg_addr : pc_q;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dbg_data  = dbg_data_q;
  assign bus.dbg_valid = dbg_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      if_inst_q   <= NOP;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      if (redirect) begin
        pc_q       <= target;
        if_inst_q  <= NOP;
        if_valid_q <= 1'b0;
      end else if (steal) begin
        if_inst_q  <= NOP;
        if_valid_q <= 1'b0;
      end else if (!bus.stall) begin
        if_inst_q  <= bus.rom_inst;
        if_pc_q    <= pc_q;
        if_valid_q <= 1'b1;
        pc_q       <= pc_inc(pc_q);
      end

      dbg_valid_q <= dbg_gnt;
      if (dbg_gnt) begin
        dbg_data_q <= bus.rom_inst;
      end
    end
  end

  // A stall during a steal would drop the instruction held in IF/ID.
  a_no_stall_in_steal: assert property (@(posedge clk) disable iff (rst) !(steal && bus.stall));

endmodule

// File: tb/tb_ifetch_seq_arb.sv
// Directed bench for ifetch_seq_arb with a cycle model of fetch and debug arbitration.
module tb_ifetch_seq_arb;
  import cpu_pkg::*;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifetch_seq_arb_if bus();

  ifetch_seq_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_inst = 32'hA000_0000 | {26'd0, bus.rom_a};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: fetch stream plus "cycles waited" counter for debug.
  logic [5:0]  m_pc     = 6'h01;
  logic [31:0] m_inst   = 32'h0;
  logic [5:0]  m_ifpc   = 6'h00;
  logic        m_valid  = 1'b0;
  logic        m_dvalid = 1'b0;
  logic [31:0] m_ddata  = 32'h0;
  int          m_wait   = 0;
  logic        m_steal  = 1'b0;

  function automatic logic m_gnt();
    return bus.dbg_req && (m_steal || (bus.stall && !(bus.br_taken || bus.jmp)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 6'h01; m_inst <= 32'h0; m_ifpc <= 6'h00; m_valid <= 1'b0;
      m_dvalid <= 1'b0; m_ddata <= 32'h0; m_wait <= 0; m_steal <= 1'b0;
    end else begin
      m_dvalid <= m_gnt();
      if (m_gnt()) m_ddata <= 32'hA000_0000 | {26'd0, bus.dbg_addr};
      if (bus.br_taken || bus.jmp) begin
        m_pc    <= bus.br_taken ? bus.br_target : bus.jmp_target;
        m_inst  <= 32'h0;
        m_valid <= 1'b0;
      end else if (m_steal) begin
        m_inst  <= 32'h0;
        m_valid <= 1'b0;
      end else if (!bus.stall) begin
        m_inst  <= 32'hA000_0000 | {26'd0, m_pc};
        m_ifpc  <= m_pc;
        m_valid <= 1'b1;
        m_pc    <= 6'((int'(m_pc) + 1) % 64);
      end
      if (m_steal) begin
        m_steal <= 1'b0;
        m_wait  <= 0;
      end else if (bus.dbg_req && !m_gnt()) begin
        if (m_wait + 1 == STARVE_MAX + 1) begin
          m_steal <= 1'b1;
          m_wait  <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else begin
        m_wait <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_dbg_gnt", {31'd0, bus.dbg_gnt}, {31'd0, m_gnt()});
      chk("m_rom_a", {26'd0, bus.rom_a}, {26'd0, (m_gnt() ? bus.dbg_addr : m_pc)});
      chk("m_if_inst", bus.if_inst, m_inst);
      chk("m_if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
      if (m_valid) chk("m_if_pc", {26'd0, bus.if_pc}, {26'd0, m_ifpc});
      chk("m_dbg_valid", {31'd0, bus.dbg_valid}, {31'd0, m_dvalid});
      if (m_dvalid) chk("m_dbg_data", bus.dbg_data, m_ddata);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_fetch(input string name, input logic [5:0] pc);
    chk({name, "_pc"}, {26'd0, bus.if_pc}, {26'd0, pc});
    chk({name, "_inst"}, bus.if_inst, 32'hA000_0000 | {26'd0, pc});
    chk({name, "_valid"}, {31'd0, bus.if_valid}, 32'd1);
  endtask

  task automatic chk_bubble(input string name);
    chk({name, "_inst"}, bus.if_inst, 32'h0);
    chk({name, "_valid"}, {31'd0, bus.if_valid}, 32'd0);
  endtask

  task automatic wait_steal(input logic [5:0] addr);
    bus.dbg_req = 1'b1; bus.dbg_addr = addr;
    for (int i = 0; i < STARVE_MAX + 1; i++) begin
      #1 chk("no_early_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
      step();
    end
    #1 chk("steal_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    chk("steal_rom_a", {26'd0, bus.rom_a}, {26'd0, addr});
  endtask

  initial begin
    bus.stall = 1'b1; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.jmp = 1'b0; bus.jmp_target = '0; bus.dbg_req = 1'b1; bus.dbg_addr = 6'h2A;
    step(); step();
    chk("rst_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
    chk("rst_rom_a", {26'd0, bus.rom_a}, 32'h01);
    chk_bubble("rst");
    chk("rst_if_pc", {26'd0, bus.if_pc}, 32'h0);
    chk("rst_dvalid", {31'd0, bus.dbg_valid}, 32'd0);
    chk("rst_ddata", bus.dbg_data, 32'h0);
    rst = 1'b0; bus.stall = 1'b0; bus.dbg_req = 1'b0;

    step(); chk_fetch("run1", 6'h01);
    step(); chk_fetch("run2", 6'h02);
    step(); chk_fetch("run3", 6'h03);

    bus.stall = 1'b1; bus.dbg_req = 1'b1; bus.dbg_addr = 6'h2A;
    #1 chk("stall_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    chk("stall_rom_a", {26'd0, bus.rom_a}, 32'h2A);
    step(); chk_fetch("stall1", 6'h03);
    chk("stall_dvalid", {31'd0, bus.dbg_valid}, 32'd1);
    chk("stall_ddata", bus.dbg_data, 32'hA000_002A);
    bus.dbg_req = 1'b0;
    step(); chk_fetch("stall2", 6'h03);
    chk("stall_dvalid_pulse", {31'd0, bus.dbg_valid}, 32'd0);
    step(); chk_fetch("stall3", 6'h03);
    bus.stall = 1'b0;
    step(); chk_fetch("unstall", 6'h04);
    step(); chk_fetch("pre_jmp", 6'h05);

    bus.jmp = 1'b1; bus.jmp_target = 6'h01;
    step(); chk_bubble("jmp");
    bus.jmp = 1'b0;
    step(); chk_fetch("jmp_tgt", 6'h01);

    bus.br_taken = 1'b1; bus.br_target = 6'h08; bus.jmp = 1'b1; bus.jmp_target = 6'h01;
    bus.stall = 1'b1;
    step(); chk_bubble("br_jmp");
    bus.br_taken = 1'b0; bus.jmp = 1'b0; bus.stall = 1'b0;
    #1 chk("br_pc", {26'd0, bus.rom_a}, 32'h08);
    step(); chk_fetch("br_tgt", 6'h08);

    wait_steal(6'h15);
    step(); chk_bubble("steal");
    chk("steal_dvalid", {31'd0, bus.dbg_valid}, 32'd1);
    chk("steal_ddata", bus.dbg_data, 32'hA000_0015);
    bus.dbg_req = 1'b0;
    step(); chk_fetch("steal_resume", 6'h0E);

    wait_steal(6'h20);
    bus.jmp = 1'b1; bus.jmp_target = 6'h10;
    step(); chk_bubble("steal_jmp");
    chk("steal_jmp_ddata", bus.dbg_data, 32'hA000_0020);
    bus.jmp = 1'b0; bus.dbg_req = 1'b0;
    step(); chk_fetch("steal_jmp_tgt", 6'h10);

    bus.jmp = 1'b1; bus.jmp_target = 6'h3E;
    step(); chk_bubble("wrap_jmp");
    bus.jmp = 1'b0;
    step(); chk_fetch("wrap3E", 6'h3E);
    step(); chk_fetch("wrap3F", 6'h3F);
    step(); chk_fetch("wrap00", 6'h00);
    step(); chk_fetch("wrap01", 6'h01);

    wait_steal(6'h33);
    rst = 1'b1;
    #1 chk("mrst_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
    chk_bubble("mrst");
    chk("mrst_if_pc", {26'd0, bus.if_pc}, 32'h0);
    chk("mrst_dvalid", {31'd0, bus.dbg_valid}, 32'd0);
    chk("mrst_ddata", bus.dbg_data, 32'h0);
    chk("mrst_rom_a", {26'd0, bus.rom_a}, 32'h01);
    bus.dbg_req = 1'b0;
    step();
    chk("mrst_no_dvalid", {31'd0, bus.dbg_valid}, 32'd0);
    rst = 1'b0;
    step(); chk_fetch("post_rst", 6'h01);
    step(); chk_fetch("post_rst2", 6'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
